// File: rtl/fifo_burst_drain.sv
// Read-side drain stage for a 1-cycle-latency FIFO: credit-based pop issue, skid buffer,
// fixed-length burst framing with first/last flags and a completed-burst counter.
module fifo_burst_drain #(
   parameter int unsigned FIFO_W    = 32,
   parameter int unsigned BUF_D     = 3,
   parameter int unsigned BURST_LEN = 4,
   parameter int unsigned CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fifo_empty,
   output logic              fifo_rd_en,
   input  logic [FIFO_W-1:0] fifo_rdata,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [FIFO_W-1:0] m_data,
   output logic              m_first,
   output logic              m_last,
   output logic [CNT_W-1:0]  burst_cnt,
   output logic              busy
);

   localparam int unsigned HW = $clog2(BUF_D + 1);
   localparam int unsigned PW = (BUF_D > 1) ? $clog2(BUF_D) : 1;
   localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   localparam logic [HW:0]   BufDepth = (HW + 1)'(BUF_D);
   localparam logic [PW-1:0] PtrLast  = PW'(BUF_D - 1);
   localparam logic [BW-1:0] BeatLast = BW'(BURST_LEN - 1);

   logic [FIFO_W-1:0] mem_q [BUF_D];
   logic [HW-1:0]     held_q, held_d;
   logic              inflight_q, inflight_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [BW-1:0]     beat_q, beat_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [HW:0] occupancy;
   logic        capture;
   logic        xfer;
   logic        at_last;

   // Credit counts words held plus the one in flight, so a capture always has room.
   assign occupancy  = {1'b0, held_q} + {{HW{1'b0}}, inflight_q};
   assign fifo_rd_en = !reset && !fifo_empty && (occupancy < BufDepth);

   assign capture   = inflight_q;
   assign m_valid   = !reset && (held_q != '0);
   assign xfer      = m_valid && m_ready;
   assign m_data    = mem_q[rd_ptr_q];
   assign at_last   = (beat_q == BeatLast);
   assign m_first   = (beat_q == '0);
   assign m_last    = at_last;
   assign burst_cnt = reset ? '0 : cnt_q;
   assign busy      = !reset && ((held_q != '0) || inflight_q || (beat_q != '0));

   always_comb begin
      held_d     = held_q;
      inflight_d = fifo_rd_en;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      beat_d     = beat_q;
      cnt_d      = cnt_q;

      if (capture && !xfer) begin
         held_d = held_q + HW'(1);
      end else if (!capture && xfer) begin
         held_d = held_q - HW'(1);
      end

      if (capture) begin
         wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PW'(1);
      end

      if (xfer) begin
         rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PW'(1);
         beat_d   = at_last ? '0 : beat_q + BW'(1);
         if (at_last) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         held_q     <= '0;
         inflight_q <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         beat_q     <= '0;
         cnt_q      <= '0;
      end else begin
         held_q     <= held_d;
         inflight_q <= inflight_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         beat_q     <= beat_d;
         cnt_q      <= cnt_d;
      end
   end

   // Storage needs no reset; held_q alone says which entries are live.
   always_ff @(posedge clk) begin
      if (!reset && capture) begin
         mem_q[wr_ptr_q] <= fifo_rdata;
      end
   end

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Bench for fifo_burst_drain: FIFO model plus a queue-based reference of popped-but-undelivered
// words; a second instance with BURST_LEN=1, CNT_W=2 exercises counter wrap.
module tb_fifo_burst_drain;

   localparam int BUF_D = 3;
   localparam int BL    = 4;

   logic        clk = 1'b0;
   logic        reset, fifo_empty, fifo_rd_en, m_valid, m_ready, m_first, m_last, busy;
   logic [31:0] fifo_rdata, m_data;
   logic [15:0] burst_cnt;

   logic        b_reset, b_empty, b_rd_en, b_valid, b_ready, b_first, b_last, b_busy;
   logic [31:0] b_rdata, b_data;
   logic [1:0]  b_cnt;

   always #5 clk = ~clk;

   fifo_burst_drain #(.FIFO_W(32), .BUF_D(BUF_D), .BURST_LEN(BL), .CNT_W(16)) u_dut (
      .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
      .fifo_rdata(fifo_rdata), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_first(m_first), .m_last(m_last), .burst_cnt(burst_cnt), .busy(busy)
   );

   fifo_burst_drain #(.FIFO_W(32), .BUF_D(3), .BURST_LEN(1), .CNT_W(2)) u_wrap (
      .clk(clk), .reset(b_reset), .fifo_empty(b_empty), .fifo_rd_en(b_rd_en),
      .fifo_rdata(b_rdata), .m_valid(b_valid), .m_ready(b_ready), .m_data(b_data),
      .m_first(b_first), .m_last(b_last), .burst_cnt(b_cnt), .busy(b_busy)
   );

   int checks   = 0;
   int failures = 0;

   logic [31:0] fq[$];   // words still inside the FIFO
   logic [31:0] eq[$];   // words popped but not yet delivered
   int          infl;    // a pop was issued at the last edge
   int          sent;
   int          bursts;

   logic        o_rd_en, o_valid, o_first, o_busy;
   logic [31:0] o_data;
   logic [15:0] o_cnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] w);
      fq.push_back(w);
      fifo_empty = 1'b0;
   endtask

   // One clock cycle: compare outputs against the reference, then advance the reference.
   task automatic tick();
      logic rd_e, valid_e, busy_e, xfer_e;
      #1;
      o_rd_en = fifo_rd_en; o_valid = m_valid; o_data = m_data;
      o_first = m_first; o_busy = busy; o_cnt = burst_cnt;
      if (reset) begin
         rd_e = 1'b0; valid_e = 1'b0; busy_e = 1'b0;
         chk("rst_cnt", burst_cnt, 0);
      end else begin
         rd_e    = (fq.size() != 0) && (eq.size() < BUF_D);
         valid_e = (eq.size() - infl) > 0;
         busy_e  = (eq.size() != 0) || (sent % BL != 0);
         chk("burst_cnt", burst_cnt, 64'(bursts % 65536));
      end
      chk("rd_en", fifo_rd_en, rd_e);
      chk("m_valid", m_valid, valid_e);
      chk("busy", busy, busy_e);
      if (valid_e) begin
         chk("m_data", m_data, eq[0]);
         chk("m_first", m_first, (sent % BL) == 0);
         chk("m_last", m_last, (sent % BL) == BL - 1);
      end
      xfer_e = valid_e && m_ready;
      @(posedge clk);
      #1;
      if (reset) begin
         eq.delete();
         infl = 0; sent = 0; bursts = 0;
         fifo_rdata = $urandom;
      end else begin
         if (xfer_e) begin
            void'(eq.pop_front());
            if (sent % BL == BL - 1) bursts++;
            sent++;
         end
         if (rd_e) begin
            fifo_rdata = fq.pop_front();
            eq.push_back(fifo_rdata);
            infl = 1;
         end else begin
            fifo_rdata = $urandom;
            infl = 0;
         end
      end
      fifo_empty = (fq.size() == 0);
   endtask

   task automatic drain(input string tag, input int bound);
      int n = 0;
      while ((eq.size() != 0 || fq.size() != 0) && n < bound) begin
         tick();
         n++;
      end
      chk(tag, n < bound, 1);
      tick();
   endtask

   initial begin
      int n, pops, first_t, last_t;
      int b_left, b_nb;
      logic b_rd, b_x;

      reset = 1'b1; fifo_empty = 1'b1; fifo_rdata = '0; m_ready = 1'b0;
      b_reset = 1'b1; b_empty = 1'b1; b_rdata = '0; b_ready = 1'b0;
      infl = 0; sent = 0; bursts = 0;

      // Reset with a non-empty FIFO; A0..A3 stay queued for the first burst.
      for (int i = 0; i < 4; i++) push(32'hA0 + i);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t1_rd_en", o_rd_en, 0);
         chk("t1_valid", o_valid, 0);
         chk("t1_busy", o_busy, 0);
      end
      reset = 1'b0;

      // Single burst on consecutive cycles.
      m_ready = 1'b1;
      n = 0; first_t = -1; last_t = -1;
      while (sent < 4 && n < 20) begin
         if (m_valid && first_t < 0) first_t = n;
         tick();
         n++;
      end
      last_t = n - 1;
      chk("t2_done", sent, 4);
      chk("t2_span", last_t - first_t, 3);
      tick();
      chk("t2_cnt", o_cnt, 1);

      // Backpressure: buffer fills to BUF_D, pops stop, head holds.
      reset = 1'b1; tick(); reset = 1'b0;
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(32'hB0 + i);
      for (int i = 0; i < 10; i++) tick();
      chk("t3_rd_en", o_rd_en, 0);
      chk("t3_valid", o_valid, 1);
      chk("t3_head", o_data, 32'hB0);
      m_ready = 1'b1;
      drain("t3_timeout", 40);
      chk("t3_cnt", o_cnt, 2);

      // Empty-to-nonempty: one pop, m_valid two cycles later, busy until burst completes.
      for (int i = 0; i < 3; i++) tick();
      push(32'h55);
      n = 0; pops = 0;
      while (n < 10) begin
         tick();
         if (o_rd_en) pops++;
         if (o_valid) break;
         n++;
      end
      chk("t4_latency", n, 2);
      chk("t4_first", o_first, 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         if (o_rd_en) pops++;
      end
      chk("t4_pops", pops, 1);
      chk("t4_busy", o_busy, 1);
      for (int i = 0; i < 3; i++) push(32'h56 + i);
      drain("t4_timeout", 20);
      chk("t4_idle", o_busy, 0);

      // Reset mid-burst with a pop in flight.
      for (int i = 0; i < 8; i++) push(32'hC0 + i);
      n = 0;
      while (!((sent % BL) == 2 && infl == 1) && n < 30) begin
         tick();
         n++;
      end
      chk("t5_reach", n < 30, 1);
      reset = 1'b1; tick(); reset = 1'b0;
      tick();
      chk("t5_valid", o_valid, 0);
      chk("t5_busy", o_busy, 0);
      drain("t5_timeout", 40);

      // Randomized traffic and backpressure.
      for (int i = 0; i < 400; i++) begin
         m_ready = ($urandom_range(0, 3) != 0);
         if (($urandom_range(0, 1) == 1) && fq.size() < 16) push($urandom);
         tick();
      end
      m_ready = 1'b1;
      drain("rand_timeout", 200);

      // Counter wrap on the BURST_LEN=1, CNT_W=2 instance.
      @(posedge clk); #1;
      b_reset = 1'b0; b_ready = 1'b1; b_left = 5; b_nb = 0; b_empty = 1'b0;
      for (int i = 0; i < 40 && b_nb < 5; i++) begin
         #1;
         chk("w_rd_empty", b_rd_en && b_empty, 0);
         b_x  = b_valid && b_ready;
         b_rd = b_rd_en;
         if (b_x) begin
            chk("w_first", b_first, 1);
            chk("w_last", b_last, 1);
            chk("w_data", b_data, 32'hD0 + b_nb);
            b_nb++;
         end
         @(posedge clk); #1;
         if (b_x) chk("w_cnt", b_cnt, 64'(b_nb % 4));
         if (b_rd) begin
            b_rdata = 32'hD0 + (5 - b_left);
            b_left--;
            b_empty = (b_left == 0);
         end
      end
      chk("w_words", b_nb, 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
